func_inverse_unit: RTL and testbench
====================================

Name: func_inverse_unit

Overview:
- Inverse of the team's forward "add then decrement" function, where forward result = (a + b - 1) mod 2^WIDTH.
- Given a forward result and the known operand a, the block recovers b = (result + 1 - a) mod 2^WIDTH.
- Streaming 2-stage pipeline with valid/ready handshakes on both sides, a wrap flag and a transaction counter.
- Sits on the decode side of a path whose encode side uses the forward function.

Parameters:
- WIDTH, 8, operand/result width.
- CNT_W, 16, width of the processed-transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept input beat.
- in_func_a  input  WIDTH  known operand a.
- in_func_result  input  WIDTH  forward-function result.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts output beat.
- out_func_b  output  WIDTH  recovered operand b.
- out_wrap  output  1  1 when (a + b) overflowed WIDTH bits in the forward function.
- out_count  output  CNT_W  number of output beats accepted since reset.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - s1_valid = s2_valid = 0, out_valid = 0, out_func_b = 0, out_wrap = 0, out_count = 0.
  - in_ready reads 1 in the first cycle after reset.
- Stage 1, on input accept (in_valid && in_ready):
  - s1_sum = in_func_result + 1, computed at WIDTH+1 bits; the carry bit is kept.
  - Register a and s1_sum; set s1_valid.
- Stage 2, on advance from s1:
  - b = (s1_sum[WIDTH-1:0] - a) mod 2^WIDTH.
  - wrap = bit WIDTH of the (WIDTH+1)-bit sum a + b.
  - Register b and wrap into the output register; set s2_valid; out_valid = s2_valid.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput: 1 beat per cycle.
- Stall rules:
  - s2 holds when out_valid && !out_ready.
  - s1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s1 advances (bubble collapsing). in_ready depends combinationally on out_ready only.
  - out_func_b and out_wrap stay stable while out_valid && !out_ready.
- Simultaneous events: output handshake and input accept in the same cycle are both honoured, with no lost or duplicated beats.
- Boundary cases:
  - result = 2^WIDTH-1 → sum low bits = 0 → b = -a mod 2^WIDTH.
  - a = 0 → b = result + 1 (wrapping).
- out_count increments by 1 on each out_valid && out_ready and wraps silently at 2^CNT_W.
- in_valid must not depend on in_ready. Input data is sampled only on accept.
- Reset mid-operation: all in-flight beats are dropped and out_valid deasserts immediately on reset assertion.

Optional Feature:
- Macro FUNC_INV_SELFCHECK_EN.
- When defined, the block:
  - adds output port out_check_err (1 bit, sticky);
  - carries the original result through stage 2;
  - recomputes the forward function ((a + b) - 1) mod 2^WIDTH at stage 2 advance;
  - sets out_check_err when the recomputed value differs from the carried result;
  - clears out_check_err only on reset.
- When undefined, the port, the extra registers and the comparator do not exist. Latency and handshake timing are identical in both builds.

Decomposition:
- Package func_pkg holds:
  - localparam DEFAULT_WIDTH = 8;
  - typedef struct packed {a, sum, carry} s1_t;
  - typedef struct packed {b, wrap} s2_t;
  - a function fwd_add_sub(a, b) matching the forward function, shared with the encode side and the self-check.
- One natural sub-module: func_pipe_stage, a generic valid/ready register slice parameterized by payload type. It is instantiated twice.

Test Plan:
1. Reset then in_valid with a=0x10, result=0x2F, out_ready=1 → out_valid 2 cycles after accept, out_func_b=0x20, out_wrap=0, out_count becomes 1.
2. a=0xF0, result=0x1F → b=0x30, out_wrap=1. a=0x00, result=0xFF → b=0x00, out_wrap=0.
3. Back-to-back 4 beats with out_ready held 0 for 5 cycles → in_ready drops after 2 beats, out data held stable, then 4 in-order outputs once out_ready=1, out_count=4.
4. Random out_ready toggling with 1000 random (a, b) pairs encoded via fwd_add_sub → every out_func_b equals the original b, in order, with no drops or duplicates.
5. Assert rst_n low with 2 beats in flight → out_valid=0 and out_count=0 immediately; after release, the next beat flows normally with 2-cycle latency.
6. FUNC_INV_SELFCHECK_EN build with force-corrupted stage-2 b → out_check_err=1 and stays 1 until reset. Uncorrupted 1000-beat run → out_check_err stays 0.

Source files
------------

// File: rtl/func_pkg.sv
// Shared types and the forward "add then decrement" function for the func_inverse_unit path.
// FUNC_INV_SELFCHECK_EN widens the stage payloads so the original result travels with each beat.
package func_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] sum;
    logic                     carry;
`ifdef FUNC_INV_SELFCHECK_EN
    logic [DEFAULT_WIDTH-1:0] result;
`endif
  } s1_t;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] b;
    logic                     wrap;
`ifdef FUNC_INV_SELFCHECK_EN
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] result;
`endif
  } s2_t;

  // Forward function used by the encode side: (a + b - 1) mod 2^DEFAULT_WIDTH.
  function automatic logic [DEFAULT_WIDTH-1:0] fwd_add_sub(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b
  );
    return a + b - DEFAULT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/func_inverse_unit_pipe_stage.sv
// Generic valid/ready register slice; payload type is a parameter.
// Accepts a new beat whenever it is empty or its current beat leaves in the same cycle.
module func_pipe_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/func_inverse_unit.sv
// Inverse of the forward add-then-decrement function: recovers b = (result + 1 - a) mod 2^WIDTH.
// Two-stage valid/ready pipeline; FUNC_INV_SELFCHECK_EN adds a sticky re-encode check (out_check_err).
module func_inverse_unit
  import func_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_func_a,
  input  logic [WIDTH-1:0] in_func_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_func_b,
  output logic             out_wrap,
  output logic [CNT_W-1:0] out_count
`ifdef FUNC_INV_SELFCHECK_EN
  ,
  output logic             out_check_err
`endif
);

  // The borrow of (sum - a) taken at WIDTH+1 bits, flipped by the carry of result+1,
  // is exactly the carry out of a + b in the forward direction.
  function automatic s2_t inverse(input s1_t s);
    logic [WIDTH:0] diff;
    s2_t            r;
    diff   = {s.carry, s.sum} - {1'b0, s.a};
    r      = '0;
    r.b    = diff[WIDTH-1:0];
    r.wrap = diff[WIDTH] ^ s.carry;
`ifdef FUNC_INV_SELFCHECK_EN
    r.a      = s.a;
    r.result = s.result;
`endif
    return r;
  endfunction

  logic [WIDTH:0]   sum_p0;
  s1_t              data_p0;
  s1_t              data_p1;
  logic             vld_p1;
  logic             rdy_p1;
  s2_t              res_p1;
  s2_t              data_p2;
  logic             vld_p2;
  logic [WIDTH-1:0] s2_b;
  logic [CNT_W-1:0] count;

  // Stage 0 -> 1: result + 1 with carry kept
  assign sum_p0 = {1'b0, in_func_result} + (WIDTH+1)'(1);

  always_comb begin
    data_p0       = '0;
    data_p0.a     = in_func_a;
    data_p0.sum   = sum_p0[WIDTH-1:0];
    data_p0.carry = sum_p0[WIDTH];
`ifdef FUNC_INV_SELFCHECK_EN
    data_p0.result = in_func_result;
`endif
  end

  func_pipe_stage #(.T(s1_t)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (data_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p1),
    .out_data  (data_p1)
  );

  // Stage 1 -> 2: subtract a, derive wrap
  assign res_p1 = inverse(data_p1);

  func_pipe_stage #(.T(s2_t)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p1),
    .in_data   (res_p1),
    .out_valid (vld_p2),
    .out_ready (out_ready),
    .out_data  (data_p2)
  );

  // Stage 2 -> output
  assign s2_b       = data_p2.b;
  assign out_valid  = vld_p2;
  assign out_func_b = s2_b;
  assign out_wrap   = data_p2.wrap;
  assign out_count  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (vld_p2 && out_ready) begin
      count <= count + CNT_W'(1);
    end
  end

`ifdef FUNC_INV_SELFCHECK_EN
  logic check_err;

  // Re-encode the delivered b and compare with the result that arrived alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_err <= 1'b0;
    end else if (vld_p2 && out_ready && (fwd_add_sub(data_p2.a, s2_b) != data_p2.result)) begin
      check_err <= 1'b1;
    end
  end

  assign out_check_err = check_err;
`endif

endmodule

// File: tb/tb_func_inverse_unit.sv
// Directed bench for func_inverse_unit: latency, boundaries, backpressure, random stream, reset.
// Define FUNC_INV_SELFCHECK_EN to also exercise out_check_err.
module tb_func_inverse_unit;
  import func_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_func_a;
  logic [7:0]  in_func_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_func_b;
  logic        out_wrap;
  logic [15:0] out_count;
`ifdef FUNC_INV_SELFCHECK_EN
  logic        out_check_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  func_inverse_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_func_a      (in_func_a),
    .in_func_result (in_func_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_func_b     (out_func_b),
    .out_wrap       (out_wrap),
    .out_count      (out_count)
`ifdef FUNC_INV_SELFCHECK_EN
    ,
    .out_check_err  (out_check_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] res);
    in_valid       = 1'b1;
    in_func_a      = a;
    in_func_result = res;
  endtask

  // One beat with out_ready high: out_valid two edges after accept, count bumps on the next.
  task automatic single_beat(input string tag, input logic [15:0] cnt_after);
    @(negedge clk);
    out_ready = 1'b1;
    drive(8'h10, 8'h2F);
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld_early"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_b"}, out_func_b, 8'h20);
    check({tag, "_wrap"}, out_wrap, 0);
    @(negedge clk);
    check({tag, "_vld_after"}, out_valid, 0);
    check({tag, "_count"}, out_count, cnt_after);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] head;
  logic [8:0] tmp9;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [8:0] cur;
  logic       acc;
  int         sent;
  int         rcvd;

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_func_a      = '0;
    in_func_result = '0;
    out_ready      = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_b", out_func_b, 0);
    check("rst_wrap", out_wrap, 0);
    check("rst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: basic latency
    single_beat("t1", 16'd1);

    // Test 2: wrap and boundary cases, back to back
    @(negedge clk);
    drive(8'hF0, 8'h1F);
    @(negedge clk);
    drive(8'h00, 8'hFF);
    @(negedge clk);
    drive(8'h00, 8'h7F);
    check("t2_vld0", out_valid, 1);
    check("t2_b0", out_func_b, 8'h30);
    check("t2_w0", out_wrap, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_b1", out_func_b, 8'h00);
    check("t2_w1", out_wrap, 0);
    @(negedge clk);
    check("t2_b2", out_func_b, 8'h80);
    check("t2_w2", out_wrap, 0);
    @(negedge clk);
    check("t2_vld_end", out_valid, 0);
    check("t2_count", out_count, 4);

    // Test 3: backpressure with four queued beats
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h01, 8'h01);
    #1 check("t3_rdy0", in_ready, 1);
    @(negedge clk);
    drive(8'h02, 8'h04);
    #1 check("t3_rdy1", in_ready, 1);
    check("t3_vld_early", out_valid, 0);
    @(negedge clk);
    drive(8'h80, 8'h7F);
    #1 check("t3_rdy_full", in_ready, 0);
    check("t3_vld", out_valid, 1);
    check("t3_b_hold", out_func_b, 8'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("t3_b_stable", out_func_b, 8'h01);
      check("t3_rdy_stall", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("t3_rdy_release", in_ready, 1);
    check("t3_b0", out_func_b, 8'h01);
    check("t3_w0", out_wrap, 0);
    @(negedge clk);
    drive(8'hFF, 8'hFF);
    check("t3_b1", out_func_b, 8'h03);
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_b2", out_func_b, 8'h00);
    check("t3_w2", out_wrap, 0);
    @(negedge clk);
    check("t3_b3", out_func_b, 8'h01);
    check("t3_w3", out_wrap, 1);
    @(negedge clk);
    check("t3_vld_end", out_valid, 0);
    check("t3_count", out_count, 8);

    // Test 4: 1000 random beats with random backpressure and input gaps
    sent = 0;
    rcvd = 0;
    acc  = 1'b0;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (acc || !in_valid) begin
        acc = 1'b0;
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          ra   = 8'($urandom);
          rb   = 8'($urandom);
          tmp9 = {1'b0, ra} + {1'b0, rb};
          cur  = {tmp9[8], rb};
          drive(ra, fwd_add_sub(ra, rb));
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t4_extra_beat", 1, 0);
        end else begin
          head = exp_q.pop_front();
          check("t4_b", out_func_b, head[7:0]);
          check("t4_wrap", out_wrap, head[8]);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sent++;
        exp_q.push_back(cur);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_all_received", rcvd, 1000);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_count", out_count, 16'd1008);
`ifdef FUNC_INV_SELFCHECK_EN
    check("t6_clean_err", out_check_err, 0);
`endif

    // Test 5: reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h05, 8'h09);
    @(negedge clk);
    drive(8'h06, 8'h0A);
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_inflight_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("t5_rst_vld", out_valid, 0);
    check("t5_rst_count", out_count, 0);
    check("t5_rst_b", out_func_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    single_beat("t5_post", 16'd1);

`ifdef FUNC_INV_SELFCHECK_EN
    // Test 6: corrupt stage-2 b while a beat is delivered
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'h10, 8'h2F);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    force dut.s2_b = 8'hAA;
    out_ready = 1'b1;
    @(negedge clk);
    release dut.s2_b;
    check("t6_err_set", out_check_err, 1);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", out_check_err, 1);
    rst_n = 1'b0;
    #1 check("t6_err_cleared", out_check_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
